sram_read_ctrl: RTL and testbench



---
 rtl/sram_pkg.sv | 23 ++
 rtl/bitline_sense.sv | 72 +++++++
 rtl/sram_read_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sram_read_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM column datapath (read controller and write
// driver): default array geometry and the read-sequencer state encoding.
// No ports; imported with `import sram_pkg::*;`.
// -----------------------------------------------------------------------------
package sram_pkg;

    // Default geometry: 16 words of 4 bits per row, 64 bitline pairs.
    localparam int DEF_WORD_SIZE = 4;
    localparam int DEF_NUM_WORDS = 16;
    localparam int DEF_NUM_COLS  = DEF_WORD_SIZE * DEF_NUM_WORDS;

    // Read sequence: precharge bitlines, fire wordline, sense, present.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        DEVELOP   = 3'd2,
        SENSE     = 3'd3,
        DONE      = 3'd4
    } rd_state_e;

endpackage

// File: rtl/bitline_sense.sv
// -----------------------------------------------------------------------------
// bitline_sense
// Combinational differential decode of the bitline pairs plus one-hot word
// mux. Bit b of word w lives on bitline[w*WORD_SIZE+b] / bitline_bar[...].
// A pair reads 1 only when BL=1 and BL_bar=0; equal rails read 0.
//
// Optional feature macro: SENSE_CHECK_EN (adds pair_invalid / sel_invalid).
//
// Ports:
//   col_select   in   NUM_WORDS  one-hot word select
//   bitline      in   NUM_COLS   true side of the pairs
//   bitline_bar  in   NUM_COLS   complement side of the pairs
//   word         out  WORD_SIZE  decoded word, 0 if select is not one-hot
//   pair_invalid out  1          (SENSE_CHECK_EN) a selected pair had BL==BL_bar
//   sel_invalid  out  1          (SENSE_CHECK_EN) select is zero or multi-hot
// -----------------------------------------------------------------------------
module bitline_sense
    import sram_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int NUM_COLS  = DEF_NUM_COLS
) (
    input  logic [NUM_WORDS-1:0] col_select,
    input  logic [NUM_COLS-1:0]  bitline,
    input  logic [NUM_COLS-1:0]  bitline_bar,
    output logic [WORD_SIZE-1:0] word
`ifdef SENSE_CHECK_EN
    ,
    output logic                 pair_invalid,
    output logic                 sel_invalid
`endif
);

    logic                 sel_onehot;
    logic [WORD_SIZE-1:0] word_or;

    // x & (x-1) clears the lowest set bit, so it is zero only for 0 or 1 bits set.
    assign sel_onehot = (col_select != '0) &&
                        ((col_select & (col_select - 1'b1)) == '0);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        word_or = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (col_select[w]) begin
                word_or |= bitline[w*WORD_SIZE +: WORD_SIZE] &
                           ~bitline_bar[w*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // A zero or multi-hot select must not OR several words together.
    assign word = sel_onehot ? word_or : '0;

`ifdef SENSE_CHECK_EN
    always_comb begin
        pair_invalid = 1'b0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (col_select[w] &&
                (|(~(bitline[w*WORD_SIZE +: WORD_SIZE] ^
                     bitline_bar[w*WORD_SIZE +: WORD_SIZE])))) begin
                pair_invalid = 1'b1;
            end
        end
    end

    assign sel_invalid = ~sel_onehot;
`endif

endmodule

// File: rtl/sram_read_ctrl.sv
// -----------------------------------------------------------------------------
// sram_read_ctrl
// Sequences one SRAM read per request: precharge the bitline pairs, enable
// the wordline while the bitlines develop, sense the selected word, latch it
// and strobe data_valid for one cycle. Synchronous active-low reset.
//
// Optional feature macro: SENSE_CHECK_EN (adds rd_err and its check logic).
//
// Ports:
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          synchronous active-low reset
//   rd_req       in   1          read request, sampled only in IDLE
//   col_select   in   NUM_WORDS  one-hot word select, captured on accept
//   bitline      in   NUM_COLS   BL pairs, true side
//   bitline_bar  in   NUM_COLS   BL pairs, complement side
//   rd_ready     out  1          high only in IDLE
//   precharge_en out  1          bitline precharge enable
//   wl_en        out  1          wordline enable
//   sense_en     out  1          sense-amplifier enable
//   data_out     out  WORD_SIZE  last sensed word (held between reads)
//   data_valid   out  1          one-cycle strobe: data_out is new
//   rd_err       out  1          (SENSE_CHECK_EN) bad select or undeveloped pair
//
// NUM_COLS must equal WORD_SIZE*NUM_WORDS; PRECHARGE_CYCLES and
// DEVELOP_CYCLES must both be at least 1.
// -----------------------------------------------------------------------------
module sram_read_ctrl
    import sram_pkg::*;
#(
    parameter int WORD_SIZE        = DEF_WORD_SIZE,
    parameter int NUM_WORDS        = DEF_NUM_WORDS,
    parameter int NUM_COLS         = DEF_NUM_COLS,
    parameter int PRECHARGE_CYCLES = 2,
    parameter int DEVELOP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req,
    input  logic [NUM_WORDS-1:0] col_select,
    input  logic [NUM_COLS-1:0]  bitline,
    input  logic [NUM_COLS-1:0]  bitline_bar,
    output logic                 rd_ready,
    output logic                 precharge_en,
    output logic                 wl_en,
    output logic                 sense_en,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_valid
`ifdef SENSE_CHECK_EN
    ,
    output logic                 rd_err
`endif
);

    localparam int MAX_CYCLES = (PRECHARGE_CYCLES > DEVELOP_CYCLES) ?
                                PRECHARGE_CYCLES : DEVELOP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEV_LAST = CNT_W'(DEVELOP_CYCLES - 1);

    rd_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [NUM_WORDS-1:0] col_q,   col_d;
    logic [WORD_SIZE-1:0] data_q,  data_d;
    logic [WORD_SIZE-1:0] sensed_word;

`ifdef SENSE_CHECK_EN
    logic err_q, err_d;
    logic pair_invalid;
    logic sel_invalid;
`endif

    // Decode works on the captured select, so later col_select changes are inert.
    bitline_sense #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_WORDS (NUM_WORDS),
        .NUM_COLS  (NUM_COLS)
    ) u_sense (
        .col_select   (col_q),
        .bitline      (bitline),
        .bitline_bar  (bitline_bar),
        .word         (sensed_word)
`ifdef SENSE_CHECK_EN
        ,
        .pair_invalid (pair_invalid),
        .sel_invalid  (sel_invalid)
`endif
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        data_d       = data_q;
        rd_ready     = 1'b0;
        precharge_en = 1'b0;
        wl_en        = 1'b0;
        sense_en     = 1'b0;
        data_valid   = 1'b0;
`ifdef SENSE_CHECK_EN
        err_d        = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                rd_ready = 1'b1;
                if (rd_req) begin
                    col_d   = col_select;
                    cnt_d   = '0;
                    state_d = PRECHARGE;
`ifdef SENSE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end

            PRECHARGE: begin
                precharge_en = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = DEVELOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DEVELOP: begin
                wl_en = 1'b1;
                if (cnt_q == DEV_LAST) begin
                    cnt_d   = '0;
                    state_d = SENSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Wordline stays on through the sense cycle; the word and the
            // error flag are registered at its end so both appear in DONE.
            SENSE: begin
                wl_en    = 1'b1;
                sense_en = 1'b1;
                data_d   = sensed_word;
`ifdef SENSE_CHECK_EN
                err_d    = pair_invalid | sel_invalid;
`endif
                state_d  = DONE;
            end

            DONE: begin
                data_valid = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values; reset is synchronous, so it lives inside the edge.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
`ifdef SENSE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            data_q  <= data_d;
`ifdef SENSE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign data_out = data_q;
`ifdef SENSE_CHECK_EN
    assign rd_err   = err_q;
`endif

endmodule

// File: tb/tb_sram_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_read_ctrl
// Directed testbench for sram_read_ctrl. Inputs change 1 ns after the rising
// edge and outputs are sampled there, clear of the active edge. Cycle 1 is
// the cycle right after the accepting edge. rd_err checks are compiled in
// only when SENSE_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_sram_read_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [15:0] col_select;
    logic [63:0] bitline;
    logic [63:0] bitline_bar;
    logic        rd_ready;
    logic        precharge_en;
    logic        wl_en;
    logic        sense_en;
    logic [3:0]  data_out;
    logic        data_valid;
`ifdef SENSE_CHECK_EN
    logic        rd_err;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sram_read_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .col_select   (col_select),
        .bitline      (bitline),
        .bitline_bar  (bitline_bar),
        .rd_ready     (rd_ready),
        .precharge_en (precharge_en),
        .wl_en        (wl_en),
        .sense_en     (sense_en),
        .data_out     (data_out),
        .data_valid   (data_valid)
`ifdef SENSE_CHECK_EN
        ,
        .rd_err       (rd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive word w onto its pairs as a fully developed differential value.
    task automatic set_word(input int w, input logic [3:0] v);
        bitline[w*4 +: 4]     = v;
        bitline_bar[w*4 +: 4] = ~v;
    endtask

    // {rd_ready, precharge_en, wl_en, sense_en, data_valid}
    function automatic logic [4:0] ctl();
        return {rd_ready, precharge_en, wl_en, sense_en, data_valid};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if (ctl() !== 5'b10000) $display("FAIL reset_ctl: got %b expected %b", ctl(), 5'b10000);
        else n_pass++;
        n_total++;
        if (data_out !== 4'h0) $display("FAIL reset_data: got %h expected %h", data_out, 4'h0);
        else n_pass++;
`ifdef SENSE_CHECK_EN
        n_total++;
        if (rd_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", rd_err);
        else n_pass++;
`endif
        rst_n = 1'b1;
        tick();
    endtask

    // Word 3 = 0xA: full cycle-by-cycle control sequence.
    task automatic test_basic();
        logic [4:0] exp_ctl;
        col_select = 16'h0008;
        rd_req     = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_ctl = {c == 7, c <= 2, (c >= 3) && (c <= 5), c == 5, c == 6};
            n_total++;
            if (ctl() !== exp_ctl)
                $display("FAIL basic_ctl_cycle%0d: got %b expected %b", c, ctl(), exp_ctl);
            else n_pass++;
            if (c == 6) begin
                n_total++;
                if (data_out !== 4'hA) $display("FAIL basic_data: got %h expected %h", data_out, 4'hA);
                else n_pass++;
            end
            tick();
        end
    endtask

    // rd_req pulsed mid-read with a new select must be dropped entirely.
    task automatic test_busy_ignore();
        int         strobes = 0;
        int         ready_cnt = 0;
        logic [3:0] seen = 4'h0;
        col_select = 16'h0008;
        rd_req     = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin
                rd_req     = 1'b1;
                col_select = 16'h0001;
            end
            if (c == 4) rd_req = 1'b0;
            if (data_valid === 1'b1) begin
                strobes++;
                seen = data_out;
            end
            if (c >= 7 && rd_ready === 1'b1) ready_cnt++;
            tick();
        end
        n_total++;
        if (strobes !== 1) $display("FAIL busy_strobes: got %0d expected 1", strobes);
        else n_pass++;
        n_total++;
        if (seen !== 4'hA) $display("FAIL busy_data: got %h expected %h", seen, 4'hA);
        else n_pass++;
        n_total++;
        if (ready_cnt !== 8) $display("FAIL busy_idle_after: got %0d ready cycles expected 8", ready_cnt);
        else n_pass++;
    endtask

    // Word 0 then word 15 with rd_req held: second accept on the first IDLE.
    task automatic test_back_to_back();
        int         strobes = 0;
        int         cyc[2] = '{0, 0};
        logic [3:0] val[2] = '{4'h0, 4'h0};
        col_select = 16'h0001;
        rd_req     = 1'b1;
        tick();
        col_select = 16'h8000;
        for (int c = 1; c <= 16; c++) begin
            if (c == 8) rd_req = 1'b0;
            if (data_valid === 1'b1) begin
                if (strobes < 2) begin
                    cyc[strobes] = c;
                    val[strobes] = data_out;
                end
                strobes++;
            end
            tick();
        end
        n_total++;
        if (strobes !== 2) $display("FAIL b2b_strobes: got %0d expected 2", strobes);
        else n_pass++;
        n_total++;
        if (cyc[0] !== 6) $display("FAIL b2b_first_cycle: got %0d expected 6", cyc[0]);
        else n_pass++;
        n_total++;
        if (val[0] !== 4'h5) $display("FAIL b2b_first_data: got %h expected %h", val[0], 4'h5);
        else n_pass++;
        n_total++;
        if (cyc[1] !== 13) $display("FAIL b2b_second_cycle: got %0d expected 13", cyc[1]);
        else n_pass++;
        n_total++;
        if (val[1] !== 4'hF) $display("FAIL b2b_second_data: got %h expected %h", val[1], 4'hF);
        else n_pass++;
    endtask

    // Reset held 2 edges during DEVELOP aborts the read with no strobe.
    task automatic test_abort_reset();
        int strobes = 0;
        col_select = 16'h0001;
        rd_req     = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        n_total++;
        if (ctl() !== 5'b00100) $display("FAIL abort_in_develop: got %b expected %b", ctl(), 5'b00100);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_total++;
        if (ctl() !== 5'b10000) $display("FAIL abort_ctl: got %b expected %b", ctl(), 5'b10000);
        else n_pass++;
        n_total++;
        if (data_out !== 4'h0) $display("FAIL abort_data: got %h expected %h", data_out, 4'h0);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (data_valid === 1'b1) strobes++;
            tick();
        end
        n_total++;
        if (strobes !== 0) $display("FAIL abort_strobe: got %0d expected 0", strobes);
        else n_pass++;
    endtask

    // One complete read with bounded waits; checks data and (optionally) rd_err.
    task automatic run_read(input string name, input logic [15:0] sel,
                            input logic [3:0] exp_data, input logic exp_err);
        int  waited = 0;
        bit  got = 0;
        while (rd_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_total++;
        if (rd_ready !== 1'b1) $display("FAIL %s_ready_timeout: got %b expected 1", name, rd_ready);
        else n_pass++;
        col_select = sel;
        rd_req     = 1'b1;
        tick();
        rd_req = 1'b0;
`ifdef SENSE_CHECK_EN
        n_total++;
        if (rd_err !== 1'b0) $display("FAIL %s_err_cleared: got %b expected 0", name, rd_err);
        else n_pass++;
`endif
        for (int c = 0; c < 12 && !got; c++) begin
            if (data_valid === 1'b1) got = 1;
            else tick();
        end
        n_total++;
        if (!got) $display("FAIL %s_valid_timeout: got no data_valid expected one", name);
        else n_pass++;
        n_total++;
        if (data_out !== exp_data)
            $display("FAIL %s_data: got %h expected %h (err_expected=%0b)", name, data_out, exp_data, exp_err);
        else n_pass++;
`ifdef SENSE_CHECK_EN
        n_total++;
        if (rd_err !== exp_err) $display("FAIL %s_err: got %b expected %b", name, rd_err, exp_err);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_invalid_select();
        run_read("multi_hot", 16'h0011, 4'h0, 1'b1);
        run_read("zero_sel",  16'h0000, 4'h0, 1'b1);
        run_read("valid_after_bad", 16'h0008, 4'hA, 1'b0);
    endtask

    // Word 2 = 0xF but bit 0 has BL = BL_bar = 1, so that bit senses 0.
    task automatic test_undeveloped();
        set_word(2, 4'hF);
        bitline[8]     = 1'b1;
        bitline_bar[8] = 1'b1;
        run_read("undeveloped", 16'h0004, 4'hE, 1'b1);
        set_word(2, 4'hF);
        run_read("developed", 16'h0004, 4'hF, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rd_req      = 1'b0;
        col_select  = 16'h0000;
        bitline     = '0;
        bitline_bar = '0;
        for (int w = 0; w < 16; w++) set_word(w, 4'(w));
        set_word(0, 4'h5);
        set_word(3, 4'hA);
        set_word(15, 4'hF);

        test_reset();
        test_basic();
        test_busy_ignore();
        test_back_to_back();
        test_abort_reset();
        test_invalid_select();
        test_undeveloped();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
